// File: rtl/bounce_gen.sv
// ============================================================================
// bounce_gen : turns a clean level command into a repeatable contact-bounce
//              waveform (first edge, BOUNCES glitch pairs, 2^PERIOD_W hold)
// Revision   : 1.0
// ============================================================================
`default_nettype none

module bounce_gen #(
    parameter int          BOUNCES  = 3,
    parameter int          PERIOD_W = 8,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clean,
    output logic bouncy,
    output logic busy,
    output logic done
);

    localparam int                  TOTAL   = 1 + 2 * BOUNCES;
    localparam int                  EW      = $clog2(TOTAL + 1);
    localparam logic [EW-1:0]       C_TOTAL = EW'(TOTAL);
    localparam logic [EW-1:0]       C_EONE  = EW'(1);
    localparam logic [PERIOD_W-1:0] C_CONE  = PERIOD_W'(1);
    localparam logic [PERIOD_W-1:0] C_HOLD  = '1;
    localparam logic [15:0]         C_SEED  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0]         C_MASK  = 16'hB400;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BOUNCE = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                level_q, level_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [EW-1:0]       edges_q, edges_d;
    logic                bouncy_q, bouncy_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [PERIOD_W-1:0] w_interval;

    // Odd interval keeps every intermediate level an even number of cycles long
    assign w_interval = {lfsr_q[PERIOD_W-1:1], 1'b1};
    assign lfsr_d     = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? C_MASK : 16'h0000);

    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        cnt_d    = cnt_q;
        edges_d  = edges_q;
        bouncy_d = bouncy_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                bouncy_d = level_q;
                busy_d   = 1'b0;
                if (clean != level_q) begin
                    bouncy_d = clean;
                    busy_d   = 1'b1;
                    edges_d  = C_EONE;
                    if (BOUNCES > 0) begin
                        cnt_d   = w_interval;
                        state_d = S_BOUNCE;
                    end else begin
                        cnt_d   = C_HOLD;
                        state_d = S_HOLD;
                    end
                end
            end
            S_BOUNCE: begin
                if (cnt_q == '0) begin
                    bouncy_d = ~bouncy_q;
                    edges_d  = edges_q + C_EONE;
                    if (edges_d < C_TOTAL) begin
                        cnt_d = w_interval;
                    end else begin
                        cnt_d   = C_HOLD;
                        state_d = S_HOLD;
                    end
                end else begin
                    cnt_d = cnt_q - C_CONE;
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    level_d = bouncy_q;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - C_CONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            level_q  <= 1'b0;
            lfsr_q   <= C_SEED;
            cnt_q    <= '0;
            edges_q  <= '0;
            bouncy_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            lfsr_q   <= lfsr_d;
            cnt_q    <= cnt_d;
            edges_q  <= edges_d;
            bouncy_q <= bouncy_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bouncy = bouncy_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

`default_nettype wire

// File: tb/tb_bounce_gen.sv
// ============================================================================
// tb_bounce_gen : self-checking bench for bounce_gen against an edge-time model
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_bounce_gen;

    localparam logic [15:0] SEED   = 16'hACE1;
    localparam int          BUDGET = 3000;

    logic clk = 1'b0;
    logic rst_n, clean, clean0;
    logic bouncy, busy, done;
    logic bouncy0, busy0, done0;

    always #5 clk = ~clk;

    bounce_gen dut (
        .clk(clk), .rst_n(rst_n), .clean(clean),
        .bouncy(bouncy), .busy(busy), .done(done)
    );

    bounce_gen #(.BOUNCES(0), .PERIOD_W(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .clean(clean0),
        .bouncy(bouncy0), .busy(busy0), .done(done0)
    );

    int cyc = 0, last_rst = 0;
    int passed = 0, total = 0, both_hi = 0;
    int eq[$], dq[$], eq0[$], dq0[$], exp_t[$], ref_pat[$];
    int exp_done, ref_done, start_s;
    logic prev_b, prev_b0;

    // Edge index bookkeeping: events are stamped with the posedge that caused them
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) last_rst = cyc;
            #1;
            if (bouncy !== prev_b) begin eq.push_back(cyc); prev_b = bouncy; end
            if (bouncy0 !== prev_b0) begin eq0.push_back(cyc); prev_b0 = bouncy0; end
            if (done === 1'b1) dq.push_back(cyc);
            if (done0 === 1'b1) dq0.push_back(cyc);
            if (done === 1'b1 && busy === 1'b1) both_hi++;
            if (done0 === 1'b1 && busy0 === 1'b1) both_hi++;
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [15:0] lfsr_adv(input int n);
        logic [15:0] v = SEED;
        for (int i = 0; i < n; i++)
            v = (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
        return v;
    endfunction

    // Expected edge posedges of one sequence starting at edge s, reset at edge r
    task automatic build_model(input int s, input int r, input int b, input int pw);
        int t, n;
        exp_t.delete();
        t = s;
        exp_t.push_back(t);
        for (int i = 1; i < 1 + 2 * b; i++) begin
            n = (int'(lfsr_adv(t - 1 - r)) & ((1 << pw) - 1)) | 1;
            t = t + n + 1;
            exp_t.push_back(t);
        end
        exp_done = t + (1 << pw);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clean = 1'b1; clean0 = 1'b0;
        repeat (3) begin
            step();
            total++; if (bouncy !== 1'b0) $display("FAIL reset_bouncy: got %b expected 0", bouncy); else passed++;
            total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
            total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passed++;
            total++; if (bouncy0 !== 1'b0) $display("FAIL reset_bouncy0: got %b expected 0", bouncy0); else passed++;
        end
        eq.delete(); dq.delete();
        rst_n = 1'b1;
        start_s = cyc + 1;
        step();
        total++; if (bouncy !== 1'b1) $display("FAIL release_bouncy: got %b expected 1", bouncy); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL release_busy: got %b expected 1", busy); else passed++;
    endtask

    task automatic test_defaults();
        int k = 0, g;
        build_model(start_s, last_rst, 3, 8);
        while (dq.size() == 0 && k < BUDGET) begin step(); k++; end
        total++;
        if (dq.size() == 0) begin $display("FAIL defaults_timeout: got no done expected done"); return; end
        passed++;
        total++; if (eq.size() !== 7) $display("FAIL defaults_count: got %0d expected 7", eq.size()); else passed++;
        for (int i = 0; i < eq.size() && i < exp_t.size(); i++) begin
            total++; if (eq[i] !== exp_t[i]) $display("FAIL defaults_edge%0d: got %0d expected %0d", i, eq[i], exp_t[i]); else passed++;
        end
        for (int i = 1; i < eq.size(); i++) begin
            g = eq[i] - eq[i-1];
            total++; if (!(g % 2 == 0 && g >= 2 && g <= 256)) $display("FAIL defaults_gap%0d: got %0d expected even 2..256", i, g); else passed++;
        end
        total++; if (dq[0] !== exp_done) $display("FAIL defaults_done_time: got %0d expected %0d", dq[0], exp_done); else passed++;
        total++; if (bouncy !== 1'b1) $display("FAIL defaults_final: got %b expected 1", bouncy); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL defaults_busy_at_done: got %b expected 0", busy); else passed++;
        ref_pat.delete();
        foreach (eq[i]) ref_pat.push_back(eq[i] - start_s);
        ref_done = dq[0] - start_s;
    endtask

    task automatic test_no_bounce();
        int k = 0, s;
        repeat ($urandom_range(1, 5)) step();
        eq0.delete(); dq0.delete();
        clean0 = 1'b1;
        s = cyc + 1;
        step();
        total++; if (bouncy0 !== 1'b1) $display("FAIL nob_first_edge: got %b expected 1", bouncy0); else passed++;
        while (dq0.size() == 0 && k < BUDGET) begin step(); k++; end
        total++;
        if (dq0.size() == 0) begin $display("FAIL nob_timeout: got no done expected done"); return; end
        passed++;
        total++; if (dq0[0] !== s + 16) $display("FAIL nob_done_time: got %0d expected %0d", dq0[0], s + 16); else passed++;
        total++; if (eq0.size() !== 1) $display("FAIL nob_edge_count: got %0d expected 1", eq0.size()); else passed++;
        total++; if (busy0 !== 1'b0) $display("FAIL nob_busy_at_done: got %b expected 0", busy0); else passed++;
        step();
        total++; if (done0 !== 1'b0) $display("FAIL nob_done_width: got %b expected 0", done0); else passed++;
        total++; if (busy0 !== 1'b0 || bouncy0 !== 1'b1) $display("FAIL nob_settled: got busy=%b bouncy=%b expected busy=0 bouncy=1", busy0, bouncy0); else passed++;
    endtask

    task automatic test_fall();
        int k = 0;
        repeat ($urandom_range(1, 6)) step();
        eq.delete(); dq.delete();
        clean = 1'b0;
        build_model(cyc + 1, last_rst, 3, 8);
        while (dq.size() == 0 && k < BUDGET) begin step(); k++; end
        total++;
        if (dq.size() == 0) begin $display("FAIL fall_timeout: got no done expected done"); return; end
        passed++;
        total++; if (eq.size() !== 7) $display("FAIL fall_count: got %0d expected 7", eq.size()); else passed++;
        for (int i = 0; i < eq.size() && i < exp_t.size(); i++) begin
            total++; if (eq[i] !== exp_t[i]) $display("FAIL fall_edge%0d: got %0d expected %0d", i, eq[i], exp_t[i]); else passed++;
        end
        total++; if (dq[0] !== exp_done) $display("FAIL fall_done_time: got %0d expected %0d", dq[0], exp_done); else passed++;
        total++; if (bouncy !== 1'b0) $display("FAIL fall_final: got %b expected 0", bouncy); else passed++;
    endtask

    task automatic test_mid_change();
        int k = 0, d;
        repeat ($urandom_range(1, 6)) step();
        eq.delete(); dq.delete();
        clean = 1'b1;
        build_model(cyc + 1, last_rst, 3, 8);
        repeat ($urandom_range(2, 5)) step();
        clean = 1'b0;
        while (dq.size() == 0 && k < BUDGET) begin step(); k++; end
        total++;
        if (dq.size() == 0) begin $display("FAIL mid_timeout: got no done expected done"); return; end
        passed++;
        total++; if (eq.size() !== 7) $display("FAIL mid_rise_count: got %0d expected 7", eq.size()); else passed++;
        for (int i = 0; i < eq.size() && i < exp_t.size(); i++) begin
            total++; if (eq[i] !== exp_t[i]) $display("FAIL mid_rise_edge%0d: got %0d expected %0d", i, eq[i], exp_t[i]); else passed++;
        end
        total++; if (dq[0] !== exp_done) $display("FAIL mid_rise_done: got %0d expected %0d", dq[0], exp_done); else passed++;
        total++; if (bouncy !== 1'b1) $display("FAIL mid_rise_final: got %b expected 1", bouncy); else passed++;
        d = dq[0];
        eq.delete(); dq.delete();
        step();
        total++; if (bouncy !== 1'b0 || busy !== 1'b1) $display("FAIL mid_reverse_start: got bouncy=%b busy=%b expected bouncy=0 busy=1", bouncy, busy); else passed++;
        build_model(d + 1, last_rst, 3, 8);
        k = 0;
        while (dq.size() == 0 && k < BUDGET) begin step(); k++; end
        total++;
        if (dq.size() == 0) begin $display("FAIL mid_fall_timeout: got no done expected done"); return; end
        passed++;
        for (int i = 0; i < eq.size() && i < exp_t.size(); i++) begin
            total++; if (eq[i] !== exp_t[i]) $display("FAIL mid_fall_edge%0d: got %0d expected %0d", i, eq[i], exp_t[i]); else passed++;
        end
        total++; if (dq[0] !== exp_done) $display("FAIL mid_fall_done: got %0d expected %0d", dq[0], exp_done); else passed++;
        total++; if (bouncy !== 1'b0) $display("FAIL mid_fall_final: got %b expected 0", bouncy); else passed++;
    endtask

    task automatic test_reset_mid();
        int k = 0, s;
        repeat ($urandom_range(1, 6)) step();
        clean = 1'b1;
        repeat ($urandom_range(3, 5)) step();
        rst_n = 1'b0;
        step();
        total++; if (bouncy !== 1'b0 || busy !== 1'b0 || done !== 1'b0) $display("FAIL rmid_reset: got bouncy=%b busy=%b done=%b expected 0 0 0", bouncy, busy, done); else passed++;
        eq.delete(); dq.delete();
        rst_n = 1'b1;
        s = cyc + 1;
        step();
        total++; if (bouncy !== 1'b1 || busy !== 1'b1) $display("FAIL rmid_restart: got bouncy=%b busy=%b expected 1 1", bouncy, busy); else passed++;
        while (dq.size() == 0 && k < BUDGET) begin step(); k++; end
        total++;
        if (dq.size() == 0) begin $display("FAIL rmid_timeout: got no done expected done"); return; end
        passed++;
        total++; if (eq.size() !== ref_pat.size()) $display("FAIL rmid_count: got %0d expected %0d", eq.size(), ref_pat.size()); else passed++;
        for (int i = 0; i < eq.size() && i < ref_pat.size(); i++) begin
            total++; if (eq[i] - s !== ref_pat[i]) $display("FAIL rmid_replay%0d: got %0d expected %0d", i, eq[i] - s, ref_pat[i]); else passed++;
        end
        total++; if (dq[0] - s !== ref_done) $display("FAIL rmid_done: got %0d expected %0d", dq[0] - s, ref_done); else passed++;
    endtask

    task automatic test_exclusive();
        total++; if (both_hi !== 0) $display("FAIL done_busy_overlap: got %0d expected 0", both_hi); else passed++;
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_no_bounce();
        test_fall();
        test_mid_change();
        test_reset_mid();
        test_exclusive();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
